// File: rtl/lc3b_microsequencer_pkg.sv
// Shared constants for the LC-3b microsequencer: condition codes of the
// micro-instruction COND field, well-known micro-states and opcodes.
package lc3b_pkg;

  typedef enum logic [1:0] {
    COND_UNCOND = 2'b00,
    COND_MEM    = 2'b01,
    COND_BR     = 2'b10,
    COND_ADDR   = 2'b11
  } cond_e;

  localparam logic [5:0] STATE_FETCH  = 6'd18;
  localparam logic [5:0] STATE_DECODE = 6'd32;

  localparam logic [3:0] OP_BR   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LDB  = 4'd2;
  localparam logic [3:0] OP_STB  = 4'd3;
  localparam logic [3:0] OP_JSR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_LDW  = 4'd6;
  localparam logic [3:0] OP_STW  = 4'd7;
  localparam logic [3:0] OP_RTI  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_SHF  = 4'd13;
  localparam logic [3:0] OP_LEA  = 4'd14;
  localparam logic [3:0] OP_TRAP = 4'd15;

  // Branch enable: any condition code selected by IR[11:9] that is set.
  function automatic logic ben_eval(input logic [2:0] ir_nzp, input logic n,
                                    input logic z, input logic p);
    return (ir_nzp[2] & n) | (ir_nzp[1] & z) | (ir_nzp[0] & p);
  endfunction

endpackage

// File: rtl/lc3b_microsequencer_if.sv
// Micro-instruction fields, datapath inputs and sequencer outputs bundled
// between the control store / datapath (master) and the sequencer (slave).
interface lc3b_microsequencer_if #(parameter int STATE_W = 6);
  logic               ird;
  logic [1:0]         cond;
  logic [STATE_W-1:0] j;
  logic               ld_ben;
  logic [15:0]        ir;
  logic               n;
  logic               z;
  logic               p;
  logic               r;
  logic [STATE_W-1:0] state;
  logic               ben;
  logic               mem_wait;
  logic               mem_timeout;

  modport master (
    output ird, cond, j, ld_ben, ir, n, z, p, r,
    input  state, ben, mem_wait, mem_timeout
  );

  modport slave (
    input  ird, cond, j, ld_ben, ir, n, z, p, r,
    output state, ben, mem_wait, mem_timeout
  );
endinterface

// File: rtl/lc3b_microsequencer_ben.sv
// Branch-enable register: captures the selected n/z/p match when loaded.
module lc3b_ben_reg
  import lc3b_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ld,
  input  logic [2:0] i_ir_nzp,
  input  logic       i_n,
  input  logic       i_z,
  input  logic       i_p,
  output logic       o_ben
);

  logic r_ben;

  // Load BEN when requested, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_ben <= 1'b0;
    else if (i_ld) r_ben <= ben_eval(i_ir_nzp, i_n, i_z, i_p);
  end

  assign o_ben = r_ben;

endmodule

// File: rtl/lc3b_microsequencer.sv
// LC-3b microsequencer: next-state selection, micro-state register, memory
// wait counter and sticky timeout flag. A timeout freezes state and BEN
// until reset so the hung access can be inspected.
module lc3b_microsequencer
  import lc3b_pkg::*;
#(
  parameter int STATE_W     = 6,
  parameter int RESET_STATE = 18,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                   i_clk,
  input logic                   i_rst,
  lc3b_microsequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout;
  logic               w_ben;
  logic               w_waiting;
  logic               w_br;
  logic               w_mem;
  logic               w_addr;
  logic [STATE_W-1:0] w_next;

  assign w_waiting = (bus.cond == COND_MEM) && !bus.r;
  assign w_br      = (bus.cond == COND_BR)   && w_ben;
  assign w_mem     = (bus.cond == COND_MEM)  && bus.r;
  assign w_addr    = (bus.cond == COND_ADDR) && bus.ir[11];

  // BEN is frozen together with the state once a timeout has been flagged.
  lc3b_ben_reg u_ben (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ld     (bus.ld_ben && !r_timeout),
    .i_ir_nzp (bus.ir[11:9]),
    .i_n      (bus.n),
    .i_z      (bus.z),
    .i_p      (bus.p),
    .o_ben    (w_ben)
  );

  // Next micro-state: opcode dispatch on IRD, else J with COND bits OR-ed in.
  always_comb begin
    w_next = r_state;
    if (bus.ird) w_next = STATE_W'(bus.ir[15:12]);
    else         w_next = bus.j | STATE_W'({w_br, w_mem, w_addr});
  end

  // Micro-state register; holds while the timeout flag is set.
  always_ff @(posedge i_clk) begin
    if (i_rst)           r_state <= STATE_W'(RESET_STATE);
    else if (!r_timeout) r_state <= w_next;
  end

  // Consecutive not-ready counter; any non-waiting cycle restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst)           r_cnt <= '0;
    else if (!w_waiting) r_cnt <= '0;
    else if (!r_timeout) r_cnt <= r_cnt + 1'b1;
  end

  // Sticky timeout on the last allowed wait cycle still seeing r=0.
  always_ff @(posedge i_clk) begin
    if (i_rst)                              r_timeout <= 1'b0;
    else if (w_waiting && r_cnt == CNT_LAST) r_timeout <= 1'b1;
  end

  assign bus.state       = r_state;
  assign bus.ben         = w_ben;
  assign bus.mem_wait    = w_waiting;
  assign bus.mem_timeout = r_timeout;

endmodule
